// File: rtl/alu_seq_divider_19bit_if.sv
// Start/done handshake between the control unit (master) and the sequential divider (slave).
interface alu_seq_divider_19bit_if #(
  parameter int WIDTH = 19
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             ovf;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero, ovf
  );
endinterface

// File: rtl/alu_seq_divider_19bit.sv
// Multi-cycle signed restoring divider: quotient truncates toward zero, remainder takes the dividend's sign.
//
// state  | meaning
// IDLE   | waiting for start
// CALC   | one restoring step per cycle, WIDTH steps
// FIX    | sign correction, results registered
// DONE   | one-cycle done pulse, may accept a new start
module alu_seq_divider_19bit #(
  parameter int WIDTH = 19
) (
  input  logic                         clk,
  input  logic                         rst,
  alu_seq_divider_19bit_if.slave       bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH:0]   dsr_mag_q;
  logic             sign_q, sign_r, ovf_pend;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             dz_q, ovf_q;
  logic             busy_c, done_c;

  logic             accept;
  logic             dsr_zero;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH:0]   dsr_ext, dsr_mag;
  logic [WIDTH+1:0] shifted, trial;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign accept   = bus.start && (state == S_IDLE || state == S_DONE);
  assign dsr_zero = (bus.divisor == '0);

  // A WIDTH-bit unsigned magnitude still holds 2^(WIDTH-1) for the most-negative dividend.
  assign dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign dsr_ext = {bus.divisor[WIDTH-1], bus.divisor};
  assign dsr_mag = dsr_ext[WIDTH] ? -dsr_ext : dsr_ext;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr_mag_q};

  assign q_fix = sign_q ? -quo_q : quo_q;
  assign r_fix = sign_r ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = dsr_zero ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == CW'(WIDTH-1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = accept ? (dsr_zero ? S_DONE : S_CALC) : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state)
      S_CALC, S_FIX: busy_c = 1'b1;
      S_DONE:        done_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_mag_q   <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      ovf_pend    <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (accept) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= dvd_mag;
      dsr_mag_q <= dsr_mag;
      sign_q    <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      sign_r    <= bus.dividend[WIDTH-1];
      ovf_pend  <= (bus.dividend == MIN_VAL) && (bus.divisor == '1);
      dz_q      <= dsr_zero;
      ovf_q     <= 1'b0;
      if (dsr_zero) begin
        quotient_q  <= '0;
        remainder_q <= '0;
      end
    end else begin
      case (state)
        S_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
          // Negative trial means the divisor did not fit: keep the shifted value (restore).
          rem_q <= trial[WIDTH+1] ? shifted[WIDTH:0] : trial[WIDTH:0];
        end
        S_FIX: begin
          quotient_q  <= q_fix;
          remainder_q <= r_fix;
          ovf_q       <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.div_by_zero = dz_q;
  assign bus.ovf         = ovf_q;
endmodule

// File: tb/tb_alu_seq_divider_19bit.sv
// Directed-vector bench for the 19-bit sequential signed divider.
module tb_alu_seq_divider_19bit;
  localparam int WIDTH = 19;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  alu_seq_divider_19bit_if #(.WIDTH(WIDTH)) bus ();

  alu_seq_divider_19bit #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled on the following posedge (cycle 0).
  task automatic launch(input int a, input int b);
    bus.dividend = WIDTH'(a);
    bus.divisor  = WIDTH'(b);
    bus.start    = 1'b1;
  endtask

  // Observes cycles 1.. at negedges until done; poke > 0 pulses a rogue start in that cycle.
  task automatic wait_done(input string tag, input int exp_q, input int exp_r,
                           input int exp_dz, input int exp_ovf, input int exp_lat,
                           input int exp_busy, input int poke);
    int n;
    int busy_bad;
    busy_bad = 0;
    n = 1;
    @(negedge clk);
    while (n < 100) begin
      bus.start = (n == poke);
      if (n == 1) begin
        bus.dividend = WIDTH'($urandom);
        bus.divisor  = WIDTH'($urandom);
      end
      if (n == poke) begin
        bus.dividend = WIDTH'(1234);
        bus.divisor  = '0;
      end
      if (bus.done) break;
      if (int'(bus.busy) != exp_busy) busy_bad++;
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check_val({tag, " latency"}, n, exp_lat);
    check_val({tag, " busy_before_done"}, busy_bad, 0);
    check_val({tag, " busy_at_done"}, int'(bus.busy), 0);
    check_val({tag, " quotient"}, $signed(bus.quotient), exp_q);
    check_val({tag, " remainder"}, $signed(bus.remainder), exp_r);
    check_val({tag, " div_by_zero"}, int'(bus.div_by_zero), exp_dz);
    check_val({tag, " ovf"}, int'(bus.ovf), exp_ovf);
  endtask

  initial begin
    int done_seen;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(negedge clk);
    check_val("rst quotient", $signed(bus.quotient), 0);
    check_val("rst remainder", $signed(bus.remainder), 0);
    check_val("rst busy", int'(bus.busy), 0);
    check_val("rst done", int'(bus.done), 0);
    check_val("rst div_by_zero", int'(bus.div_by_zero), 0);
    check_val("rst ovf", int'(bus.ovf), 0);
    rst = 1'b0;
    @(negedge clk);

    launch(100, 7);    wait_done("100/7",   14,  2, 0, 0, 21, 1, 0);
    @(negedge clk);
    launch(-100, 7);   wait_done("-100/7", -14, -2, 0, 0, 21, 1, 0);
    @(negedge clk);
    launch(100, -7);   wait_done("100/-7", -14,  2, 0, 0, 21, 1, 0);
    @(negedge clk);
    launch(-100, -7);  wait_done("-100/-7", 14, -2, 0, 0, 21, 1, 0);
    @(negedge clk);
    launch(5, 0);      wait_done("5/0",      0,  0, 1, 0, 1, 0, 0);
    @(negedge clk);
    launch(9, 3);      wait_done("9/3",      3,  0, 0, 0, 21, 1, 0);
    @(negedge clk);
    launch(-262144, -1); wait_done("min/-1", -262144, 0, 0, 1, 21, 1, 0);
    @(negedge clk);
    launch(262143, 1); wait_done("max/1", 262143, 0, 0, 0, 21, 1, 0);
    @(negedge clk);
    launch(1000, 33);  wait_done("ignored_start", 30, 10, 0, 0, 21, 1, 5);

    // Start held in the DONE cycle: second done lands 21 cycles after the first.
    @(negedge clk);
    launch(100, 7);    wait_done("b2b first",  14, 2, 0, 0, 21, 1, 0);
    launch(-77, 8);    wait_done("b2b second", -9, -5, 0, 0, 21, 1, 0);

    // Reset in cycle 10 of a division.
    @(negedge clk);
    launch(100, 7);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_mid busy", int'(bus.busy), 0);
    check_val("rst_mid done", int'(bus.done), 0);
    check_val("rst_mid quotient", $signed(bus.quotient), 0);
    check_val("rst_mid remainder", $signed(bus.remainder), 0);
    done_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    check_val("rst_mid no_activity", done_seen, 0);
    launch(50, 5);     wait_done("50/5", 10, 0, 0, 0, 21, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
